// File: rtl/shift_rows_pipe.sv
// Registered, handshaked Rijndael ShiftRows/InvShiftRows stage (NB = 4, 6, 8) with an output FIFO.
// Optional per-byte parity carry/check is enabled by defining SHIFT_ROWS_PARITY_EN.
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [32*NB-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_data,
  output logic            out_inv,
  output logic [2:0]      occupancy
`ifdef SHIFT_ROWS_PARITY_EN
  ,
  input  logic [4*NB-1:0] parity_in,
  output logic [4*NB-1:0] parity_out,
  output logic            parity_err
`endif
);

  localparam int W  = 32 * NB;
  localparam int PB = 4 * NB;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SHIFT_ROWS_PARITY_EN
  localparam int EW = W + PB + 1;
`else
  localparam int EW = W + 1;
`endif

  // Wide blocks (NB = 8) skip offset 2 on the lower two rows.
  function automatic int row_shift(input int r);
    if (NB == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  logic [W-1:0]  fwd_data, inv_data, perm_data;
  logic [EW-1:0] entry_in;

`ifdef SHIFT_ROWS_PARITY_EN
  logic [PB-1:0] fwd_par, inv_par, perm_par, calc_par;
  logic          parity_err_q, parity_err_d;
`endif

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int FC = (c + row_shift(r)) % NB;
      localparam int IC = (c - row_shift(r) + NB) % NB;
      assign fwd_data[W-1-8*(r+4*c) -: 8] = in_data[W-1-8*(r+4*FC) -: 8];
      assign inv_data[W-1-8*(r+4*c) -: 8] = in_data[W-1-8*(r+4*IC) -: 8];
`ifdef SHIFT_ROWS_PARITY_EN
      assign fwd_par[PB-1-(r+4*c)] = parity_in[PB-1-(r+4*FC)];
      assign inv_par[PB-1-(r+4*c)] = parity_in[PB-1-(r+4*IC)];
`endif
    end
  end

  assign perm_data = in_inv ? inv_data : fwd_data;

`ifdef SHIFT_ROWS_PARITY_EN
  for (genvar k = 0; k < PB; k++) begin : g_par
    assign calc_par[PB-1-k] = ^in_data[W-1-8*k -: 8];
  end
  assign perm_par = in_inv ? inv_par : fwd_par;
  assign entry_in = {in_inv, perm_par, perm_data};
`else
  assign entry_in = {in_inv, perm_data};
`endif

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]    occ_q, occ_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [EW-1:0] head_q, head_d;
  logic          push, pop;

  assign in_ready  = (occ_q < 3'(DEPTH));
  assign out_valid = (occ_q != 3'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head is registered separately so it can hold its last value once the FIFO drains.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = 3'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = entry_in;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_d = next_ptr(rd_ptr_q);
      if (push && !pop)      occ_d = occ_q + 3'd1;
      else if (pop && !push) occ_d = occ_q - 3'd1;
      if (occ_d != 3'd0) head_d = mem_d[rd_ptr_d];
    end
  end

`ifdef SHIFT_ROWS_PARITY_EN
  always_comb begin
    parity_err_d = parity_err_q;
    if (flush) parity_err_d = 1'b0;
    else if (push && (parity_in != calc_par)) parity_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
  assign parity_out = head_q[W+PB-1:W];
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= 3'd0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      head_q   <= head_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign out_data  = head_q[W-1:0];
  assign out_inv   = head_q[EW-1];
  assign occupancy = occ_q;

endmodule
